// File: rtl/rr4_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr4_arbiter_pkg
// Brief    : Shared encodings and constants for the 4-way round-robin arbiter.
// Revision : 1.0
// ============================================================================
package rr4_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int NREQ             = 4;
    localparam int MAX_HOLD_DEFAULT = 8;

endpackage
`default_nettype wire

// File: rtl/rr4_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rr4_arbiter_if
// Brief    : Request/grant bundle between requesters (master) and arbiter (slave).
// Revision : 1.0
// ============================================================================
interface rr4_arbiter_if;
    import rr4_arbiter_pkg::*;

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [1:0]      gnt_id;
    logic            gnt_valid;
    logic            preempt;

    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  preempt
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output preempt
    );

endinterface
`default_nettype wire

// File: rtl/rr4_arbiter_decoder.sv
`default_nettype none
// ============================================================================
// Module   : b2to4_decoder
// Brief    : 2-to-4 one-hot decoder.
// Revision : 1.0
// ============================================================================
module b2to4_decoder (
    input  wire logic [1:0] sel_i,
    output logic      [3:0] onehot_o
);

    assign onehot_o = 4'b0001 << sel_i;

endmodule
`default_nettype wire

// File: rtl/rr4_arbiter_select.sv
`default_nettype none
// ============================================================================
// Module   : rr4_select
// Brief    : Rotating-priority selector; first set request at or after ptr_i.
// Revision : 1.0
// ============================================================================
module rr4_select (
    input  wire logic [3:0] req_i,
    input  wire logic [1:0] ptr_i,
    output logic      [1:0] idx_o,
    output logic            any_o
);

    logic [7:0] w_dbl;
    logic [3:0] w_rot;
    logic [1:0] w_off;

    // Rotate so ptr_i lands at bit 0, encode, then add ptr_i back (mod 4).
    assign w_dbl = {req_i, req_i};
    assign w_rot = w_dbl[ptr_i +: 4];

    always_comb begin
        w_off = 2'd0;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
        else if (w_rot[3]) w_off = 2'd3;
    end

    assign idx_o = ptr_i + w_off;
    assign any_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/rr4_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr4_arbiter
// Brief    : 4-requester round-robin arbiter with bounded grant hold time.
// Revision : 1.0
// ============================================================================
module rr4_arbiter
    import rr4_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
    parameter int CNT_W    = 4
) (
    input wire logic    clock,
    input wire logic    reset_,
    rr4_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] c_cnt_max   = '1;
    localparam logic [CNT_W-1:0] c_hold_last = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    state_t           state_q;
    logic [1:0]       gnt_id_q;
    logic             gnt_valid_q;
    logic             preempt_q;
    logic [1:0]       ptr_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] hold_cnt_d;

    logic [1:0]       w_sel_idx;
    logic             w_sel_any;
    logic [3:0]       w_dec;
    logic             w_timeout;

    rr4_select u_select (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .idx_o (w_sel_idx),
        .any_o (w_sel_any)
    );

    b2to4_decoder u_decoder (
        .sel_i    (gnt_id_q),
        .onehot_o (w_dec)
    );

    // Counter saturates so an unlimited hold can never wrap back into a timeout.
    assign hold_cnt_d = (hold_cnt_q == c_cnt_max) ? hold_cnt_q : hold_cnt_q + 1'b1;
    assign w_timeout  = (MAX_HOLD != 0) && (hold_cnt_q == c_hold_last);

    always_ff @(posedge clock) begin
        if (!reset_) begin
            state_q     <= IDLE;
            gnt_id_q    <= 2'd0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
            ptr_q       <= 2'd0;
            hold_cnt_q  <= '0;
        end else begin
            preempt_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_sel_any) begin
                        gnt_id_q    <= w_sel_idx;
                        gnt_valid_q <= 1'b1;
                        hold_cnt_q  <= '0;
                        state_q     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!bus.req[gnt_id_q]) begin
                        state_q     <= IDLE;
                        gnt_valid_q <= 1'b0;
                        ptr_q       <= gnt_id_q + 2'd1;
                    end else if (w_timeout) begin
                        state_q     <= IDLE;
                        gnt_valid_q <= 1'b0;
                        ptr_q       <= gnt_id_q + 2'd1;
                        preempt_q   <= 1'b1;
                    end else begin
                        hold_cnt_q  <= hold_cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = w_dec & {NREQ{gnt_valid_q}};
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.preempt   = preempt_q;

endmodule
`default_nettype wire
